dtcm_port_arbiter: RTL

//  Shares the single-ported DTCM array between three requesters: core data IF (DATA), AXI slave bridge (AXI), DMA.

---
 rtl/dtcm_arb_pkg.sv | 18 +
 rtl/dtcm_rr_pick.sv | 20 ++
 rtl/dtcm_port_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dtcm_arb_pkg.sv
// dtcm_arb_pkg: shared constants and types for the DTCM port arbiter.
// Requester indices, grant vector type and round-robin pointer encoding.
package dtcm_arb_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_DATA = 0;
  localparam int REQ_AXI  = 1;
  localparam int REQ_DMA  = 2;

  localparam int AGE_LIMIT_DEF = 8;

  typedef logic [NUM_REQ-1:0] gnt_oh_t;

  // Pointer indexes the 2-way picker: bit 0 is AXI, bit 1 is DMA.
  localparam logic RR_AXI = 1'b0;
  localparam logic RR_DMA = 1'b1;

endpackage

// File: rtl/dtcm_rr_pick.sv
// dtcm_rr_pick: 2-way round-robin picker for the AXI/DMA pair.
// The pointed-at requester wins if requesting, else the other one.
module dtcm_rr_pick
  import dtcm_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[~ptr_i]) begin
      gnt_o[~ptr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dtcm_port_arbiter.sv
// dtcm_port_arbiter: shares the single DTCM port between DATA, AXI and DMA.
// Define DTCM_ARB_AGING_EN to let long-waiting AXI/DMA requests preempt DATA.
module dtcm_port_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AGE_LIMIT  = AGE_LIMIT_DEF,
  parameter int AGE_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  data_req,
  input  logic                  data_rd0_wr1,
  input  logic [3:0]            data_strb,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_rvalid,

  input  logic                  axi_req,
  input  logic                  axi_rd0_wr1,
  input  logic [3:0]            axi_strb,
  input  logic [ADDR_WIDTH-1:0] axi_addr,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_gnt,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic                  axi_rvalid,

  input  logic                  dma_req,
  input  logic                  dma_rd0_wr1,
  input  logic [3:0]            dma_strb,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,

  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [3:0]            mem_strb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_W)) begin : g_bad_age
    $error("AGE_W too narrow for AGE_LIMIT");
  end

  gnt_oh_t               wr_v;
  logic [3:0]            strb_v  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] addr_v  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_v [NUM_REQ];

  assign wr_v = {dma_rd0_wr1, axi_rd0_wr1, data_rd0_wr1};

  assign strb_v[REQ_DATA]  = data_strb;
  assign strb_v[REQ_AXI]   = axi_strb;
  assign strb_v[REQ_DMA]   = dma_strb;
  assign addr_v[REQ_DATA]  = data_addr;
  assign addr_v[REQ_AXI]   = axi_addr;
  assign addr_v[REQ_DMA]   = dma_addr;
  assign wdata_v[REQ_DATA] = data_wdata;
  assign wdata_v[REQ_AXI]  = axi_wdata;
  assign wdata_v[REQ_DMA]  = dma_wdata;

  gnt_oh_t               gnt;
  gnt_oh_t               rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] rdata_d [NUM_REQ];
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  preempt;
  logic [1:0]            pick_req, pick_gnt;

`ifdef DTCM_ARB_AGING_EN
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] axi_age_q, axi_age_d;
  logic [AGE_W-1:0] dma_age_q, dma_age_d;
  logic [1:0]       aged;

  assign aged[0]  = axi_req && (axi_age_q == AGE_MAX);
  assign aged[1]  = dma_req && (dma_age_q == AGE_MAX);
  assign preempt  = |aged;
  // When anyone is aged only the aged ones compete, ordered by rr_ptr.
  assign pick_req = preempt ? aged : {dma_req, axi_req};

  always_comb begin
    axi_age_d = axi_age_q;
    dma_age_d = dma_age_q;
    if (!axi_req || gnt[REQ_AXI]) begin
      axi_age_d = '0;
    end else if (axi_age_q != AGE_MAX) begin
      axi_age_d = axi_age_q + AGE_W'(1);
    end
    if (!dma_req || gnt[REQ_DMA]) begin
      dma_age_d = '0;
    end else if (dma_age_q != AGE_MAX) begin
      dma_age_d = dma_age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_age_q <= '0;
      dma_age_q <= '0;
    end else begin
      axi_age_q <= axi_age_d;
      dma_age_q <= dma_age_d;
    end
  end
`else
  assign preempt  = 1'b0;
  assign pick_req = {dma_req, axi_req};
`endif

  dtcm_rr_pick u_pick (
    .req_i (pick_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (data_req && !preempt) begin
        gnt[REQ_DATA] = 1'b1;
      end else begin
        gnt[REQ_AXI] = pick_gnt[0];
        gnt[REQ_DMA] = pick_gnt[1];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt[REQ_AXI]) begin
      rr_ptr_d = RR_DMA;
    end else if (gnt[REQ_DMA]) begin
      rr_ptr_d = RR_AXI;
    end
  end

  always_comb begin
    mem_en    = |gnt;
    mem_wen   = |(gnt & wr_v);
    mem_strb  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_strb  = strb_v[i];
        mem_addr  = addr_v[i];
        mem_wdata = wdata_v[i];
      end
    end
  end

  // Grant implies request, so gnt & ~wr marks an accepted read.
  always_comb begin
    rvalid_d = gnt & ~wr_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdata_d[i] = rvalid_d[i] ? mem_rdata : rdata_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      rr_ptr_q <= RR_AXI;
      for (int i = 0; i < NUM_REQ; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      rvalid_q <= rvalid_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  assign data_gnt    = gnt[REQ_DATA];
  assign axi_gnt     = gnt[REQ_AXI];
  assign dma_gnt     = gnt[REQ_DMA];
  assign data_rvalid = rvalid_q[REQ_DATA];
  assign axi_rvalid  = rvalid_q[REQ_AXI];
  assign dma_rvalid  = rvalid_q[REQ_DMA];
  assign data_rdata  = rdata_q[REQ_DATA];
  assign axi_rdata   = rdata_q[REQ_AXI];
  assign dma_rdata   = rdata_q[REQ_DMA];

endmodule
